// File: rtl/dmem_multicycle.sv
// Byte-addressable RV32I data memory for the MA stage with a fixed multi-cycle
// access latency signalled through busywait, and misaligned-access flagging.
module dmem_multicycle #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic        misaligned,
    output logic [31:0] debug_word0
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;

    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            r_is_load;
    logic [1:0]      r_code;
    logic            r_sgn;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;

    logic            w_valid;
    logic            w_live;
    logic            w_a_load;
    logic [1:0]      w_a_code;
    logic            w_a_sgn;
    logic [AW-1:0]   w_a_addr;
    logic [31:0]     w_a_wdata;
    logic            w_fire;
    logic            w_mis;
    logic [AW-1:0]   w_idx [4];
    logic [31:0]     w_raw;
    logic [3:0]      w_lanes;
    logic            w_unused;

    // Size code is shared by loads (funct3[1:0]) and stores: 00 byte, 01 half, 1x word.
    function automatic logic [3:0] f_lanes(input logic [1:0] code);
        case (code)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [1:0] code, input logic sgn,
                                             input logic [31:0] raw);
        case (code)
            2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign w_valid  = read[3] ^ write[2];
    assign w_unused = ^address[31:AW];

    // In IDLE the access (LATENCY=1) uses the values being latched at this edge.
    assign w_live    = (r_state == S_IDLE);
    assign w_a_load  = w_live ? read[3] : r_is_load;
    assign w_a_code  = w_live ? (read[3] ? read[1:0] : write[1:0]) : r_code;
    assign w_a_sgn   = w_live ? ~read[2] : r_sgn;
    assign w_a_addr  = w_live ? address[AW-1:0] : r_addr;
    assign w_a_wdata = w_live ? writedata : r_wdata;

    assign w_fire = ((r_state == S_IDLE) && w_valid && (LATENCY == 1)) ||
                    ((r_state == S_BUSY) && (r_cnt == '0));

    assign w_mis = ((w_a_code == 2'b01) && w_a_addr[0]) ||
                   (w_a_code[1] && (w_a_addr[1:0] != 2'b00));

    assign w_lanes = f_lanes(w_a_code);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = w_a_addr + AW'(k);
        end
    end

    assign w_raw       = {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]};
    assign debug_word0 = {r_mem[3], r_mem[2], r_mem[1], r_mem[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_valid) begin
                r_cnt <= CNT_INIT;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_next = (LATENCY == 1) ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busywait = 1'b0;
        case (r_state)
            S_IDLE:  busywait = w_valid;
            S_BUSY:  busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if ((r_state == S_IDLE) && w_valid) begin
            r_is_load <= read[3];
            r_code    <= read[3] ? read[1:0] : write[1:0];
            r_sgn     <= ~read[2];
            r_addr    <= address[AW-1:0];
            r_wdata   <= writedata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_fire && !w_a_load && !w_mis) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lanes[k]) r_mem[w_idx[k]] <= w_a_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata   <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= w_fire && w_mis;
            if (w_fire && w_a_load) begin
                readdata <= w_mis ? 32'h0 : f_extend(w_a_code, w_a_sgn, w_raw);
            end
        end
    end

endmodule

// File: tb/tb_dmem_multicycle.sv
// Bench for dmem_multicycle: four instances (LATENCY 2,1,5,4) driven by directed
// and random accesses, checked against a byte-array reference model.
module tb_dmem_multicycle;

    logic        clk = 1'b0;
    logic        rst_v   [4];
    logic [3:0]  rd_v    [4];
    logic [2:0]  wr_v    [4];
    logic [31:0] ad_v    [4];
    logic [31:0] wd_v    [4];
    logic [31:0] rdata_v [4];
    logic        busy_v  [4];
    logic        mis_v   [4];
    logic [31:0] dbg_v   [4];

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_m  [4][1024];
    logic [31:0] exp_rd [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_multicycle #(
            .DEPTH_BYTES(1024),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 4)
        ) u_dut (
            .clock(clk),
            .reset(rst_v[g]),
            .read(rd_v[g]),
            .write(wr_v[g]),
            .address(ad_v[g]),
            .writedata(wd_v[g]),
            .readdata(rdata_v[g]),
            .busywait(busy_v[g]),
            .misaligned(mis_v[g]),
            .debug_word0(dbg_v[g])
        );
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word0(input int k);
        return {mem_m[k][3], mem_m[k][2], mem_m[k][1], mem_m[k][0]};
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < 1024; i++) mem_m[k][i] = 8'h00;
        exp_rd[k] = 32'h0;
    endtask

    task automatic model(input int k, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int exp_bw, output logic exp_mis);
        logic [1:0]  code;
        int          nb;
        logic [63:0] v;
        logic [31:0] idx;
        exp_mis = 1'b0;
        exp_bw  = 0;
        if ((rd[3] ^ wr[2]) == 1'b0) return;
        exp_bw  = lat_of(k);
        code    = rd[3] ? rd[1:0] : wr[1:0];
        nb      = (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
        exp_mis = ((int'(a[1:0]) % nb) != 0);
        if (rd[3]) begin
            if (exp_mis) begin
                exp_rd[k] = 32'h0;
            end else begin
                v = 64'h0;
                for (int i = 0; i < nb; i++) begin
                    idx = a + 32'(i);
                    v = v + (64'(mem_m[k][idx[9:0]]) << (8 * i));
                end
                if (nb < 4 && !rd[2] && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
                exp_rd[k] = v[31:0];
            end
        end else if (!exp_mis) begin
            for (int i = 0; i < nb; i++) begin
                idx = a + 32'(i);
                mem_m[k][idx[9:0]] = 8'((wd >> (8 * i)) & 32'hFF);
            end
        end
    endtask

    // Drives one request and counts busywait-high cycles; returns sampled in DONE (or IDLE if ignored).
    task automatic access(input int k, input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] wd, output int bw);
        @(negedge clk);
        rd_v[k] = rd;
        wr_v[k] = wr;
        ad_v[k] = a;
        wd_v[k] = wd;
        bw = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (!busy_v[k]) break;
            bw++;
            @(negedge clk);
        end
        rd_v[k] = 4'h0;
        wr_v[k] = 3'h0;
    endtask

    task automatic full(input int k, input string tag, input logic [3:0] rd,
                        input logic [2:0] wr, input logic [31:0] a, input logic [31:0] wd);
        int   exp_bw;
        int   bw;
        logic exp_mis;
        model(k, rd, wr, a, wd, exp_bw, exp_mis);
        access(k, rd, wr, a, wd, bw);
        chk({tag, ".busy_cycles"}, 32'(bw), 32'(exp_bw));
        chk({tag, ".readdata"}, rdata_v[k], exp_rd[k]);
        chk({tag, ".misaligned"}, 32'(mis_v[k]), 32'(exp_mis));
        chk({tag, ".debug_word0"}, dbg_v[k], model_word0(k));
        @(negedge clk);
        #1;
        chk({tag, ".after_mis"}, 32'(mis_v[k]), 32'h0);
        chk({tag, ".after_busy"}, 32'(busy_v[k]), 32'h0);
        chk({tag, ".after_rd"}, rdata_v[k], exp_rd[k]);
    endtask

    initial begin
        int bw;
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1;
            rd_v[k]  = 4'h0;
            wr_v[k]  = 3'h0;
            ad_v[k]  = 32'h0;
            wd_v[k]  = 32'h0;
            model_clear(k);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset.readdata", rdata_v[k], 32'h0);
            chk("reset.busywait", 32'(busy_v[k]), 32'h0);
            chk("reset.misaligned", 32'(mis_v[k]), 32'h0);
            chk("reset.debug_word0", dbg_v[k], 32'h0);
            rst_v[k] = 1'b0;
        end

        full(0, "sw_dead", 4'b0000, 3'b110, 32'h10, 32'hDEADBEEF);
        full(0, "lw_dead", 4'b1010, 3'b000, 32'h10, 32'h0);
        chk("lw_dead.value", rdata_v[0], 32'hDEADBEEF);
        chk("lw_dead.word0", dbg_v[0], 32'h0);

        full(0, "sw_lanes", 4'b0000, 3'b110, 32'h20, 32'h11223344);
        full(0, "sb_lane1", 4'b0000, 3'b100, 32'h21, 32'hFFFFFF80);
        full(0, "lw_lanes", 4'b1010, 3'b000, 32'h20, 32'h0);
        chk("lw_lanes.value", rdata_v[0], 32'h11228044);
        full(0, "lb_21", 4'b1000, 3'b000, 32'h21, 32'h0);
        chk("lb_21.value", rdata_v[0], 32'hFFFFFF80);
        full(0, "lbu_21", 4'b1100, 3'b000, 32'h21, 32'h0);
        chk("lbu_21.value", rdata_v[0], 32'h00000080);
        full(0, "lh_20", 4'b1001, 3'b000, 32'h20, 32'h0);
        chk("lh_20.value", rdata_v[0], 32'hFFFF8044);
        full(0, "lhu_22", 4'b1101, 3'b000, 32'h22, 32'h0);
        chk("lhu_22.value", rdata_v[0], 32'h00001122);

        full(0, "sw_30", 4'b0000, 3'b110, 32'h30, 32'h01020304);
        full(0, "sh_mis", 4'b0000, 3'b101, 32'h31, 32'h0000ABCD);
        full(0, "lw_30", 4'b1010, 3'b000, 32'h30, 32'h0);
        chk("lw_30.unchanged", rdata_v[0], 32'h01020304);
        full(0, "lw_mis", 4'b1010, 3'b000, 32'h32, 32'h0);
        chk("lw_mis.value", rdata_v[0], 32'h0);

        for (int k = 0; k < 3; k++) begin
            full(k, "lat_sweep", 4'b0000, 3'b110, 32'h40, 32'h0BADF00D);
            access(k, 4'b1010, 3'b110, 32'h40, 32'h0, bw);
            chk("both_set.busy_cycles", 32'(bw), 32'h0);
        end

        full(3, "pre_rst_sw", 4'b0000, 3'b110, 32'h0, 32'h99887766);
        @(negedge clk);
        rd_v[3] = 4'b0000; wr_v[3] = 3'b110; ad_v[3] = 32'h0; wd_v[3] = 32'hCAFEF00D;
        #1;
        chk("rst_mid.busy1", 32'(busy_v[3]), 32'h1);
        @(negedge clk);
        #1;
        chk("rst_mid.busy2", 32'(busy_v[3]), 32'h1);
        rst_v[3] = 1'b1;
        rd_v[3]  = 4'h0;
        wr_v[3]  = 3'h0;
        @(negedge clk);
        #1;
        model_clear(3);
        chk("rst_mid.busywait", 32'(busy_v[3]), 32'h0);
        chk("rst_mid.debug_word0", dbg_v[3], 32'h0);
        chk("rst_mid.readdata", rdata_v[3], 32'h0);
        rst_v[3] = 1'b0;
        full(3, "rst_mid.lw0", 4'b1010, 3'b000, 32'h0, 32'h0);

        full(0, "wrap_sw", 4'b0000, 3'b110, 32'h400, 32'h12345678);
        full(0, "wrap_lw", 4'b1010, 3'b000, 32'h0, 32'h0);
        chk("wrap.value", rdata_v[0], 32'h12345678);
        chk("wrap.word0", dbg_v[0], 32'h12345678);

        for (int i = 0; i < 160; i++) begin
            int          k;
            int          sel;
            logic [3:0]  rd;
            logic [2:0]  wr;
            logic [31:0] a;
            k   = i % 4;
            sel = $urandom_range(0, 9);
            a   = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FC00) : 32'h0;
            a   = a | 32'($urandom_range(0, 63));
            if (sel < 5) begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
                wr = {1'b0, 2'($urandom_range(0, 3))};
            end else if (sel < 9) begin
                rd = {1'b0, 3'($urandom_range(0, 7))};
                wr = {1'b1, 2'($urandom_range(0, 3))};
            end else begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
                wr = {1'b1, 2'($urandom_range(0, 3))};
            end
            full(k, "rand", rd, wr, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_multicycle.md
Name: dmem_multicycle

Overview:
- Parametrised byte-addressable data memory for the MA stage. Supports the full RV32I load/store set (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte lanes and sign/zero extension.
- Has a configurable access latency, signalled to the pipeline through a busywait stall handshake. Flags misaligned accesses instead of silently aligning them.
- Sits between the MA-stage control and the MA/WB pipeline register. A cache or controller can replace it later without a port change.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; power of two, at least 4.
- LATENCY, 2: cycles busywait stays high per access; at least 1.

Ports:
- clock  in  1  posedge clock.
- reset  in  1  synchronous, active-high.
- read  in  4  [3] = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- write  in  3  [2] = store enable; [1:0] = size (00 SB, 01 SH, 10 SW).
- address  in  32  byte address.
- writedata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- readdata  out  32  extended load result, registered.
- busywait  out  1  stall request to the pipeline.
- misaligned  out  1  one-cycle pulse on a misaligned access.
- debug_word0  out  32  bytes 3..0 as a little-endian word.

Behaviour:
- All state updates on posedge clock. Memory is little-endian. Index is address[log2(DEPTH_BYTES)-1:0]; upper bits are ignored, so addresses wrap.
- Reset (synchronous), when reset=1 at an edge:
  - all memory bytes = 0, state = IDLE, counter = 0;
  - readdata = 0, misaligned = 0;
  - any in-flight access is aborted and no bytes are written.
- Request validity: valid = read[3] XOR write[2]. When both are set, the request is ignored with no stall and no flag.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: busywait = valid, combinationally. On an edge with valid=1, latch op, address and writedata.
    - LATENCY=1: go to DONE and perform the access at that edge.
    - Otherwise: go to BUSY with cnt = LATENCY-2.
  - BUSY: busywait = 1. At an edge with cnt = 0, perform the access and go to DONE; otherwise decrement cnt.
  - DONE: busywait = 0 and readdata is valid for the pipeline to sample at the next edge. The still-present request is ignored. The next edge returns to IDLE.
- Cost per access: busywait high for exactly LATENCY cycles, then 1 DONE cycle. Back-to-back accesses are separated by the DONE cycle.
- Access is performed using the latched values, never the live inputs.
- Misalignment rules:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0] != 00 is misaligned.
- On a misaligned access: no memory write, readdata = 0, misaligned = 1 during the DONE cycle only.
- Load results:
  - LB: byte at addr, sign-extended.
  - LBU: byte at addr, zero-extended.
  - LH/LHU: bytes addr and addr+1, sign- or zero-extended respectively.
  - LW: 4 bytes.
  - Reserved funct3 values (011, 11x) are treated as LW.
- Store writes only the addressed lanes; all other bytes are unchanged. Size 11 is treated as SW.
- readdata changes only on a completed load (or reset). Stores and idle cycles hold it.
- misaligned is 0 in all states other than DONE.

Test Plan:
- Word store then load: SW 0xDEADBEEF @0x10 -> busywait high 2 cycles, then DONE. Subsequent LW @0x10 -> readdata = 0xDEADBEEF; debug_word0 unchanged (0).
- Byte lanes and extension:
  - SW 0x11223344 @0x20, then SB 0x80 @0x21.
  - LW @0x20 -> 0x11228044.
  - LB @0x21 -> 0xFFFFFF80.
  - LBU @0x21 -> 0x00000080.
  - LH @0x20 -> 0xFFFF8044.
  - LHU @0x22 -> 0x00001122.
- Misaligned: SH 0xABCD @0x31 -> misaligned pulses 1 cycle in DONE and memory at 0x30..0x33 is unchanged. LW @0x32 -> readdata = 0, misaligned = 1.
- Latency sweep: with LATENCY = 1, 2 and 5, count busywait-high cycles per access -> 1, 2 and 5 respectively. With read[3]=write[2]=1 -> busywait stays 0.
- Reset mid-store: start SW 0xCAFEF00D @0x0 with LATENCY=4, assert reset on the 2nd busy cycle -> busywait = 0 next cycle, state IDLE, debug_word0 = 0.
- Wrap: with DEPTH_BYTES=1024, SW 0x12345678 @0x400 -> LW @0x0 returns 0x12345678 and debug_word0 = 0x12345678.
